uart_tx_arb: RTL and testbench

- Packet-level round-robin arbiter that shares the single RS-232 transmit path (TX FIFO feeding the serializer) among P_N_REQ byte-stream requesters.
- Each requester presents a packet as a byte stream with valid/ready/last. A granted packet is copied unbroken into the TX FIFO, so bytes from different sources never interleave on the wire.
- A stall watchdog revokes the grant from a requester that stops mid-packet.

---
 rtl/uart_tx_arb.sv | 127 ++++++++++++
 tb/tb_uart_tx_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding one TX FIFO from P_N_REQ byte streams.
// Valid/ready: a byte moves on a cycle where req_valid[g] && req_ready[g]; that is exactly fifo_wr_en.
module uart_tx_arb #(
  parameter int P_N_REQ       = 4,
  parameter int P_TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [P_N_REQ-1:0]   req_valid,
  input  logic [8*P_N_REQ-1:0] req_data,
  input  logic [P_N_REQ-1:0]   req_last,
  output logic [P_N_REQ-1:0]   req_ready,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  input  logic                 fifo_full,
  output logic [P_N_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int W_PTR = (P_N_REQ > 2) ? $clog2(P_N_REQ) : 1;
  localparam int W_SUM = W_PTR + 1;
  localparam int W_CNT = $clog2(P_TIMEOUT_CYC);
  localparam logic [W_CNT-1:0]   C_CNT_MAX = W_CNT'(P_TIMEOUT_CYC - 1);
  localparam logic [W_CNT-1:0]   C_CNT_LIM = W_CNT'(P_TIMEOUT_CYC - 2);
  localparam logic [W_PTR-1:0]   C_IDX_MAX = W_PTR'(P_N_REQ - 1);
  localparam logic [W_SUM-1:0]   C_N       = W_SUM'(P_N_REQ);
  localparam logic [P_N_REQ-1:0] C_ONE     = P_N_REQ'(1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t             r_state;
  logic [P_N_REQ-1:0] r_grant;
  logic [W_PTR-1:0]   r_gidx;
  logic [W_PTR-1:0]   r_ptr;
  logic [W_CNT-1:0]   r_cnt;
  logic               r_busy;
  logic               r_timeout_err;

  logic               w_any;
  logic [W_PTR-1:0]   w_pick;
  logic [W_SUM-1:0]   w_sum;
  logic [W_PTR-1:0]   w_idx;
  logic [W_PTR-1:0]   w_gidx_inc;
  logic               w_valid_g;
  logic               w_last_g;
  logic               w_wr;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two counts work.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = 0; k < P_N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + W_SUM'(k);
      if (w_sum >= C_N) w_sum = w_sum - C_N;
      w_idx = w_sum[W_PTR-1:0];
      if (!w_any && req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_gidx_inc = (r_gidx == C_IDX_MAX) ? '0 : r_gidx + 1'b1;
  assign w_valid_g  = r_busy & req_valid[r_gidx];
  assign w_last_g   = req_last[r_gidx];
  assign w_wr       = w_valid_g & ~fifo_full;

  assign req_ready    = r_grant & {P_N_REQ{~fifo_full}};
  assign fifo_wr_en   = w_wr;
  assign fifo_wr_data = r_busy ? req_data[{r_gidx, 3'b000} +: 8] : 8'h00;
  assign grant        = r_grant;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_XFER;
            r_busy  <= 1'b1;
            r_grant <= C_ONE << w_pick;
            r_gidx  <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_XFER: begin
          if (w_wr) begin
            r_cnt <= '0;
            if (w_last_g) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_grant <= '0;
              r_ptr   <= w_gidx_inc;
            end
          end else if (!req_valid[r_gidx] && !fifo_full) begin
            // A full FIFO freezes the count, so serializer back-pressure never trips it.
            if (r_cnt >= C_CNT_LIM) begin
              r_cnt         <= C_CNT_MAX;
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
              r_grant       <= '0;
              r_ptr         <= w_gidx_inc;
              r_timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a spec-level model.
module tb_uart_tx_arb;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [7:0]     fifo_wr_data;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arb #(.P_N_REQ(N), .P_TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner of the link, rotating priority, stall cycles since last byte.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_stall = 0;
  logic m_to  = 1'b0;
  int n_model_wr = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    logic         e_wr;
    int           pick;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_stall = 0;
      m_to    = 1'b0;
    end
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_ready = fifo_full ? '0 : e_grant;
    e_wr    = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
    chk("m_grant", grant, e_grant);
    chk("m_busy", busy, m_owner >= 0);
    chk("m_timeout", timeout_err, m_to);
    chk("m_ready", req_ready, e_ready);
    chk("m_wr_en", fifo_wr_en, e_wr);
    if (e_wr) chk("m_wr_data", fifo_wr_data, req_data[8*m_owner +: 8]);
    if (rst_n) begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (pick < 0 && req_valid[j]) pick = j;
        end
        if (pick >= 0) begin
          m_owner = pick;
          m_stall = 0;
        end
      end else if (e_wr) begin
        n_model_wr++;
        m_stall = 0;
        if (req_last[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (!req_valid[m_owner] && !fifo_full) begin
        m_stall++;
        if (m_stall >= T - 1) begin
          m_to    = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]        = v;
    req_data[8*i +: 8]  = d;
    req_last[i]         = l;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int ncyc);
    int rem[N];
    logic [N-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && c < ncyc - 100 && $urandom_range(0, 3) == 0)
          rem[i] = $urandom_range(1, 5);
        if (rem[i] > 0) begin
          if (!req_valid[i] || acc[i]) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
          req_valid[i] = ($urandom_range(0, 7) != 0);
          req_last[i]  = (rem[i] == 1);
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      #2;
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (acc[i]) rem[i]--;
      step();
    end
  endtask

  initial begin
    logic [N-1:0] rr_exp [9];
    int n_to;
    int n_rdy;
    int first_k;
    int wr_before;
    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);

    // single packet from req0
    set_req(0, 1'b1, 8'h48, 1'b0);
    #1 chk("sp_no_grant_yet", grant, 0);
    step(); #1;
    chk("sp_grant", grant, 4'b0001);
    chk("sp_wr0", fifo_wr_en, 1);
    chk("sp_data0", fifo_wr_data, 8'h48);
    step();
    set_req(0, 1'b1, 8'h69, 1'b1);
    #1;
    chk("sp_wr1", fifo_wr_en, 1);
    chk("sp_data1", fifo_wr_data, 8'h69);
    step();
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(1, 1'b1, 8'h02, 1'b1);
    #1;
    chk("sp_release", grant, 0);
    chk("sp_busy_low", busy, 0);
    step(); #1 chk("sp_ptr1", grant, 4'b0010);
    step(); #1 chk("sp_bubble", grant, 0);
    step(); #1 chk("sp_ptr_wrap", grant, 4'b0001);
    step(); idle_inputs();

    // round-robin with all four continuously valid
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'hC0 + i), 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(); #1;
      chk($sformatf("rr_grant_%0d", k), grant, rr_exp[k]);
      chk($sformatf("rr_wr_%0d", k), fifo_wr_en, rr_exp[k] != 0);
    end
    step(); idle_inputs();

    // back-pressure mid-packet must not trip the watchdog
    reset_dut();
    set_req(2, 1'b1, 8'hA0, 1'b0);
    step(); #1;
    chk("bp_wr0", fifo_wr_en, 1);
    chk("bp_data0", fifo_wr_data, 8'hA0);
    step();
    set_req(2, 1'b1, 8'hA1, 1'b0);
    fifo_full = 1'b1;
    #1 chk("bp_ready_full", req_ready[2], 0);
    n_to = 0;
    n_rdy = 0;
    for (int k = 0; k < 5000; k++) begin
      step(); #1;
      if (timeout_err) n_to++;
      if (req_ready[2] || fifo_wr_en) n_rdy++;
    end
    chk("bp_no_timeout", n_to, 0);
    chk("bp_ready_low", n_rdy, 0);
    chk("bp_still_granted", grant, 4'b0100);
    fifo_full = 1'b0;
    #1;
    chk("bp_wr1", fifo_wr_en, 1);
    chk("bp_data1", fifo_wr_data, 8'hA1);
    step();
    set_req(2, 1'b1, 8'hA2, 1'b1);
    #1 chk("bp_data2", fifo_wr_data, 8'hA2);
    step(); idle_inputs();
    #1 chk("bp_done", grant, 0);

    // watchdog: req1 stops after one byte
    reset_dut();
    set_req(1, 1'b1, 8'h11, 1'b0);
    step(); #1;
    chk("wd_data", fifo_wr_data, 8'h11);
    first_k = 0;
    n_to = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) req_valid[1] = 1'b0;
      #1;
      if (timeout_err) begin
        n_to++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("wd_pulse_cycle", first_k, 16);
    chk("wd_grant_clear", grant, 0);
    set_req(0, 1'b1, 8'h0A, 1'b1);
    set_req(2, 1'b1, 8'h2A, 1'b1);
    step(); #1;
    if (timeout_err) n_to++;
    chk("wd_pulse_width", n_to, 1);
    chk("wd_next_req2", grant, 4'b0100);
    step(); idle_inputs();

    // asynchronous reset while req3 holds the grant
    reset_dut();
    set_req(3, 1'b1, 8'h33, 1'b0);
    step(); #1;
    chk("ar_granted", grant, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", req_ready, 0);
    chk("ar_wr_en", fifo_wr_en, 0);
    step(); step();
    rst_n = 1'b1;
    set_req(1, 1'b1, 8'h21, 1'b1);
    set_req(3, 1'b1, 8'h43, 1'b1);
    step(); #1 chk("ar_ptr0", grant, 4'b0010);
    step(); idle_inputs();

    // last byte lands on the cycle the watchdog would expire
    reset_dut();
    set_req(0, 1'b1, 8'h5A, 1'b0);
    step(); #1 chk("race_first", fifo_wr_data, 8'h5A);
    n_to = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) req_valid[0] = 1'b0;
      if (k == 15) set_req(0, 1'b1, 8'hA5, 1'b1);
      #1;
      if (timeout_err) n_to++;
    end
    chk("race_wr_last", fifo_wr_en, 1);
    chk("race_data_last", fifo_wr_data, 8'hA5);
    step();
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(1, 1'b1, 8'h02, 1'b1);
    #1;
    if (timeout_err) n_to++;
    chk("race_no_timeout", n_to, 0);
    chk("race_release", grant, 0);
    step(); #1 chk("race_ptr_adv", grant, 4'b0010);
    step(); idle_inputs();

    // randomized traffic against the model
    reset_dut();
    wr_before = n_model_wr;
    run_random(3000);
    idle_inputs();
    repeat (40) step();
    chk("rnd_activity", (n_model_wr - wr_before) > 200, 1);
    chk("rnd_idle_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
